fetch_pc_unit: RTL and testbench

- Program-counter and fetch-address stage that sits directly upstream of the instruction decoder/controller in the single-cycle MIPS-subset core.
- Holds the PC, computes next-PC from decoded control (jump, jr, beq, bne, bltz) and datapath flags, and drives the instruction-memory word address.
- Adds a RUN/HALT state machine for syscall halt and external resume, plus cycle, retired-instruction and taken-branch counters for the debug display.

---
 rtl/fetch_pc_unit.sv | 119 +++++++++++
 tb/tb_fetch_pc_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Program counter and fetch-address stage for the single-cycle MIPS-subset core.
// Computes next PC from decoded control, runs a RUN/HALT machine and keeps debug counters.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               halt_req,
  input  logic               pc_jump,
  input  logic               jr,
  input  logic               beq,
  input  logic               bne,
  input  logic               bltz,
  input  logic               alu_equal,
  input  logic               rs_sign,
  input  logic [25:0]        jump_index,
  input  logic [15:0]        branch_imm,
  input  logic [31:0]        jr_target,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               halted,
  output logic               redirect,
  output logic               jr_misalign,
  output logic [31:0]        cycle_count,
  output logic [31:0]        retired_count,
  output logic [31:0]        taken_count
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] taken_q, taken_d;

  logic        branch_taken;
  logic [31:0] pc_plus4_w;
  logic [31:0] branch_off;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] jr_tgt;
  logic [31:0] next_pc;

  assign pc_plus4_w   = pc_q + 32'd4;
  assign branch_taken = (beq & alu_equal) | (bne & ~alu_equal) | (bltz & rs_sign);
  assign branch_off   = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign branch_tgt   = pc_plus4_w + branch_off;
  assign jump_tgt     = {pc_plus4_w[31:28], jump_index, 2'b00};
  assign jr_tgt       = {jr_target[31:2], 2'b00};

  // Priority: jr over j/jal over taken branch over sequential.
  always_comb begin
    next_pc = pc_plus4_w;
    if (jr)                next_pc = jr_tgt;
    else if (pc_jump)      next_pc = jump_tgt;
    else if (branch_taken) next_pc = branch_tgt;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cycle_d    = cycle_q;
    retired_d  = retired_q;
    taken_d    = taken_q;
    misalign_d = misalign_q;
    if (state_q == S_RUN) begin
      pc_d      = next_pc;
      cycle_d   = cycle_q + 32'd1;
      retired_d = retired_q + 32'd1;
      if (branch_taken && !jr && !pc_jump) taken_d = taken_q + 32'd1;
      if (jr && (jr_target[1:0] != 2'b00)) misalign_d = 1'b1;
      // The syscall still retires and the PC moves past it before halting.
      if (halt_req) state_d = S_HALT;
    end else begin
      if (go) state_d = S_RUN;
    end
    halted_d = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      halted_q   <= 1'b0;
      pc_q       <= RESET_PC;
      cycle_q    <= 32'd0;
      retired_q  <= 32'd0;
      taken_q    <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      pc_q       <= pc_d;
      cycle_q    <= cycle_d;
      retired_q  <= retired_d;
      taken_q    <= taken_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc            = pc_q;
  assign pc_plus4      = pc_plus4_w;
  assign imem_addr     = pc_q[IMEM_AW+1:2];
  assign halted        = halted_q;
  assign redirect      = jr | pc_jump | branch_taken;
  assign jr_misalign   = misalign_q;
  assign cycle_count   = cycle_q;
  assign retired_count = retired_q;
  assign taken_count   = taken_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes hand-computed expectations,
// a monitor pops them and compares against the DUT around each clock edge.
module tb_fetch_pc_unit;

  localparam int IMEM_AW = 10;

  logic               clk = 1'b0;
  logic               rst_n, go, halt_req, pc_jump, jr, beq, bne, bltz, alu_equal, rs_sign;
  logic [25:0]        jump_index;
  logic [15:0]        branch_imm;
  logic [31:0]        jr_target;
  logic [31:0]        pc, pc_plus4, cycle_count, retired_count, taken_count;
  logic [IMEM_AW-1:0] imem_addr;
  logic               halted, redirect, jr_misalign;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        redirect;
    logic [31:0] pc;
    logic        halted;
    logic        mis;
    logic [31:0] cyc;
    logic [31:0] taken;
  } exp_t;

  exp_t sb[$];

  fetch_pc_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(IMEM_AW)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .halt_req(halt_req), .pc_jump(pc_jump),
    .jr(jr), .beq(beq), .bne(bne), .bltz(bltz), .alu_equal(alu_equal),
    .rs_sign(rs_sign), .jump_index(jump_index), .branch_imm(branch_imm),
    .jr_target(jr_target), .pc(pc), .pc_plus4(pc_plus4), .imem_addr(imem_addr),
    .halted(halted), .redirect(redirect), .jr_misalign(jr_misalign),
    .cycle_count(cycle_count), .retired_count(retired_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input string field, input logic [31:0] act,
                         input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    end
  endtask

  // Monitor: redirect is checked just before the edge, registered state just after it.
  initial begin
    exp_t e;
    logic [IMEM_AW-1:0] ia;
    forever begin
      @(negedge clk);
      #4;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check32(e.name, "redirect", {31'd0, redirect}, {31'd0, e.redirect});
        @(posedge clk);
        #1;
        ia = e.pc[IMEM_AW+1:2];
        check32(e.name, "pc", pc, e.pc);
        check32(e.name, "pc_plus4", pc_plus4, e.pc + 32'd4);
        check32(e.name, "imem_addr", {22'd0, imem_addr}, {22'd0, ia});
        check32(e.name, "halted", {31'd0, halted}, {31'd0, e.halted});
        check32(e.name, "jr_misalign", {31'd0, jr_misalign}, {31'd0, e.mis});
        check32(e.name, "cycle_count", cycle_count, e.cyc);
        check32(e.name, "retired_count", retired_count, e.cyc);
        check32(e.name, "taken_count", taken_count, e.taken);
      end
    end
  end

  // One cycle of stimulus plus the expected state after the following rising edge.
  // ctl = {rst_n, go, halt_req, pc_jump, jr, beq, bne, bltz, alu_equal, rs_sign}
  task automatic step(input string name, input logic [9:0] ctl, input logic [25:0] ji,
                      input logic [15:0] bi, input logic [31:0] jt, input logic e_redir,
                      input logic [31:0] e_pc, input logic e_halt, input logic e_mis,
                      input logic [31:0] e_cyc, input logic [31:0] e_taken);
    exp_t e;
    @(negedge clk);
    #2;
    {rst_n, go, halt_req, pc_jump, jr, beq, bne, bltz, alu_equal, rs_sign} = ctl;
    jump_index = ji;
    branch_imm = bi;
    jr_target  = jt;
    e.name = name; e.redirect = e_redir; e.pc = e_pc; e.halted = e_halt;
    e.mis = e_mis; e.cyc = e_cyc; e.taken = e_taken;
    sb.push_back(e);
  endtask

  initial begin
    {rst_n, go, halt_req, pc_jump, jr, beq, bne, bltz, alu_equal, rs_sign} = 10'b0;
    jump_index = '0; branch_imm = '0; jr_target = '0;
    //                     rgh pjbbb ar
    step("reset1",   10'b000_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0000, 0, 0, 0,  0);
    step("reset_go", 10'b010_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0000, 0, 0, 0,  0);
    step("seq0_go",  10'b110_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0004, 0, 0, 1,  0);
    step("seq1",     10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0008, 0, 0, 2,  0);
    step("seq2",     10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_000C, 0, 0, 3,  0);
    step("jr_40",    10'b100_01000_00, 26'h0,  16'h0,    32'h0000_0040, 1'b1, 32'h0000_0040, 0, 0, 4,  0);
    step("beq_tk",   10'b100_00100_10, 26'h0,  16'hFFFE, 32'h0,         1'b1, 32'h0000_003C, 0, 0, 5,  1);
    step("jr_40b",   10'b100_01000_00, 26'h0,  16'h0,    32'h0000_0040, 1'b1, 32'h0000_0040, 0, 0, 6,  1);
    step("beq_nt",   10'b100_00100_00, 26'h0,  16'hFFFE, 32'h0,         1'b0, 32'h0000_0044, 0, 0, 7,  1);
    step("bne_nt",   10'b100_00010_10, 26'h0,  16'h0010, 32'h0,         1'b0, 32'h0000_0048, 0, 0, 8,  1);
    step("jr_hi",    10'b100_01000_00, 26'h0,  16'h0,    32'h1000_0010, 1'b1, 32'h1000_0010, 0, 0, 9,  1);
    step("jr_prio",  10'b100_11100_10, 26'h40, 16'h0004, 32'h0000_0203, 1'b1, 32'h0000_0200, 0, 1, 10, 1);
    step("jump",     10'b100_10000_00, 26'h40, 16'h0,    32'h0,         1'b1, 32'h0000_0100, 0, 1, 11, 1);
    step("jr_80",    10'b100_01000_00, 26'h0,  16'h0,    32'h0000_0080, 1'b1, 32'h0000_0080, 0, 1, 12, 1);
    step("halt",     10'b101_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0084, 1, 1, 13, 1);
    step("hold1",    10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0084, 1, 1, 13, 1);
    step("hold2",    10'b101_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0084, 1, 1, 13, 1);
    step("hold_beq", 10'b100_00100_10, 26'h0,  16'h0008, 32'h0,         1'b1, 32'h0000_0084, 1, 1, 13, 1);
    step("hold3",    10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0084, 1, 1, 13, 1);
    step("hold4",    10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0084, 1, 1, 13, 1);
    step("resume",   10'b110_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0084, 0, 1, 13, 1);
    step("after_go", 10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0088, 0, 1, 14, 1);
    step("jr_top",   10'b100_01000_00, 26'h0,  16'h0,    32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 0, 1, 15, 1);
    step("pc_wrap",  10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0000, 0, 1, 16, 1);
    step("jr_10",    10'b100_01000_00, 26'h0,  16'h0,    32'h0000_0010, 1'b1, 32'h0000_0010, 0, 1, 17, 1);
    step("bltz_tk",  10'b100_00001_01, 26'h0,  16'h0001, 32'h0,         1'b1, 32'h0000_0018, 0, 1, 18, 2);
    step("bltz_nt",  10'b100_00001_00, 26'h0,  16'h0001, 32'h0,         1'b0, 32'h0000_001C, 0, 1, 19, 2);
    step("halt_jr",  10'b101_01000_00, 26'h0,  16'h0,    32'h0000_0040, 1'b1, 32'h0000_0040, 1, 1, 20, 2);
    step("rst_halt", 10'b010_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0000, 0, 0, 0,  0);
    step("post_rst", 10'b100_00000_00, 26'h0,  16'h0,    32'h0,         1'b0, 32'h0000_0004, 0, 0, 1,  0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
